// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM encoding, the port ids and the data-access legality check.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int   DEFAULT_TIMEOUT = 16;
   localparam logic PORT_IF         = 1'b0;
   localparam logic PORT_D          = 1'b1;

   // A data access is legal when its size is one-hot and naturally aligned.
   function automatic logic size_legal(input logic       is_byte,
                                       input logic       is_half,
                                       input logic       is_word,
                                       input logic [1:0] lsb);
      logic legal;
      legal = 1'b0;
      case ({is_byte, is_half, is_word})
         3'b100:  legal = 1'b1;
         3'b010:  legal = (lsb[0] == 1'b0);
         3'b001:  legal = (lsb == 2'b00);
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles; expired is high in the TIMEOUT-th enabled cycle.
// clear has priority so each access starts from zero.
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count_r;

   // Cycle counter for the access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count_r <= 8'd0;
      else if (clear)
         count_r <= 8'd0;
      else if (enable)
         count_r <= count_r + 8'd1;
   end

   assign expired = enable && (count_r == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a data port
// sharing one single-outstanding memory interface, with a BUSY timeout.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_byte,
   input  logic              d_half,
   input  logic              d_word,
   input  logic [31:0]       d_wdata,
   output logic              d_done,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              m_valid,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_we,
   output logic              m_byte,
   output logic              m_half,
   output logic              m_word,
   output logic [31:0]       m_wdata,
   input  logic              m_ack,
   input  logic [31:0]       m_rdata
);

   localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

   arb_state_t state_r, next_state_s;
   logic       last_grant_r, port_r;
   logic       grant_s, grant_port_s, d_legal_s, expired_s;
   logic       enter_resp_s, resp_port_s, err_s, capture_s, start_busy_s;

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_r != BUSY),
      .enable  (state_r == BUSY),
      .expired (expired_s)
   );

   // Round-robin pick; only consumed while IDLE.
   always_comb begin
      grant_s   = if_req | d_req;
      d_legal_s = size_legal(d_byte, d_half, d_word, d_addr[1:0]);
      if (if_req && d_req)
         grant_port_s = (last_grant_r == PORT_IF) ? PORT_D : PORT_IF;
      else if (d_req)
         grant_port_s = PORT_D;
      else
         grant_port_s = PORT_IF;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_r <= IDLE;
      else
         state_r <= next_state_s;
   end

   // FSM next-state logic; an illegal data request skips the memory entirely.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_s)
               next_state_s = (grant_port_s == PORT_D && !d_legal_s) ? RESP : BUSY;
            else
               next_state_s = IDLE;
         end
         BUSY: begin
            if (m_ack || expired_s)
               next_state_s = RESP;
            else
               next_state_s = BUSY;
         end
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // FSM output decode; an ack in the last timeout cycle still counts as success.
   always_comb begin
      start_busy_s = (state_r == IDLE) && (next_state_s == BUSY);
      enter_resp_s = (state_r != RESP) && (next_state_s == RESP);
      resp_port_s  = (state_r == BUSY) ? port_r : grant_port_s;
      capture_s    = (state_r == BUSY) && m_ack;
      if (state_r == IDLE)
         err_s = 1'b1;
      else
         err_s = !m_ack;
   end

   // Completion pulses and memory strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_done <= 1'b0;
         if_err  <= 1'b0;
         d_done  <= 1'b0;
         d_err   <= 1'b0;
         m_valid <= 1'b0;
      end else begin
         if_done <= enter_resp_s && (resp_port_s == PORT_IF);
         if_err  <= enter_resp_s && (resp_port_s == PORT_IF) && err_s;
         d_done  <= enter_resp_s && (resp_port_s == PORT_D);
         d_err   <= enter_resp_s && (resp_port_s == PORT_D) && err_s;
         m_valid <= (next_state_s == BUSY);
      end
   end

   // Grant bookkeeping and access latch; m_* stay frozen for the whole access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_r <= PORT_D;
         port_r       <= PORT_IF;
         m_addr       <= '0;
         m_we         <= 1'b0;
         m_byte       <= 1'b0;
         m_half       <= 1'b0;
         m_word       <= 1'b0;
         m_wdata      <= 32'd0;
      end else begin
         if (state_r == IDLE && grant_s) begin
            last_grant_r <= grant_port_s;
            port_r       <= grant_port_s;
         end
         if (start_busy_s && grant_port_s == PORT_IF) begin
            m_addr  <= if_addr & WORD_MASK;
            m_we    <= 1'b0;
            m_byte  <= 1'b0;
            m_half  <= 1'b0;
            m_word  <= 1'b1;
            m_wdata <= 32'd0;
         end else if (start_busy_s) begin
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_byte  <= d_byte;
            m_half  <= d_half;
            m_word  <= d_word;
            m_wdata <= d_wdata;
         end
      end
   end

   // Read-data capture on a successful ack only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rdata <= 32'd0;
         d_rdata  <= 32'd0;
      end else begin
         if (capture_s && port_r == PORT_IF)
            if_rdata <= m_rdata;
         if (capture_s && port_r == PORT_D)
            d_rdata <= m_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we, d_byte, d_half, d_word, m_ack;
   logic [11:0] if_addr, d_addr;
   logic [31:0] d_wdata, m_rdata;
   logic        if_done, if_err, d_done, d_err, m_valid, m_we, m_byte, m_half, m_word;
   logic [31:0] if_rdata, d_rdata, m_wdata;
   logic [11:0] m_addr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byte(d_byte), .d_half(d_half),
      .d_word(d_word), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .m_valid(m_valid), .m_addr(m_addr), .m_we(m_we), .m_byte(m_byte), .m_half(m_half),
      .m_word(m_word), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
   );

   task automatic test_reset();
      rst = 1'b0;
      if_req = 1'b0; if_addr = 12'h000;
      d_req = 1'b0; d_we = 1'b0; d_addr = 12'h000;
      d_byte = 1'b0; d_half = 1'b0; d_word = 1'b0; d_wdata = 32'd0;
      m_ack = 1'b0; m_rdata = 32'd0;
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if ({m_valid, m_we, m_byte, m_half, m_word, if_done, if_err, d_done, d_err} !== 9'd0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 0", {m_valid, m_we, m_byte, m_half, m_word, if_done, if_err, d_done, d_err});
      end
      n_cmp++;
      if ({m_addr, m_wdata, if_rdata, d_rdata} !== 108'd0) begin
         n_bad++; $display("FAIL reset_data: addr %h wdata %h if_rdata %h d_rdata %h want 0", m_addr, m_wdata, if_rdata, d_rdata);
      end
   endtask

   task automatic test_round_robin();
      logic [11:0] exp_addr [4];
      logic        exp_d [4];
      int          grants;
      int          cyc;
      logic        done_seen;
      exp_addr[0] = 12'h200; exp_addr[1] = 12'h044; exp_addr[2] = 12'h200; exp_addr[3] = 12'h044;
      exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b1;
      if_req = 1'b1; if_addr = 12'h200;
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h044; d_word = 1'b1;
      rst = 1'b1;
      grants = 0; cyc = 0; done_seen = 1'b1;
      while (grants < 4 && cyc < 60) begin
         @(negedge clk); cyc++;
         m_ack = 1'b0;
         if (if_done || d_done) begin
            done_seen = 1'b1;
            n_cmp++;
            if (grants == 0 || {if_done, d_done} !== {!exp_d[grants-1], exp_d[grants-1]}) begin
               n_bad++; $display("FAIL rr_done_port: got if/d %b%b after grant %0d", if_done, d_done, grants);
            end
         end
         if (m_valid) begin
            n_cmp++;
            if (m_addr !== exp_addr[grants] || done_seen !== 1'b1) begin
               n_bad++; $display("FAIL rr_grant%0d: m_addr %h want %h, prior done %b want 1", grants, m_addr, exp_addr[grants], done_seen);
            end
            done_seen = 1'b0;
            grants++;
            m_ack = 1'b1;
            m_rdata = 32'hA000_0000 + 32'(grants);
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      n_cmp++;
      if (grants != 4) begin
         n_bad++; $display("FAIL rr_count: got %0d grants want 4 within budget", grants);
      end
      @(negedge clk);
      m_ack = 1'b0;
      n_cmp++;
      if ({if_done, d_done, d_err} !== 3'b010 || d_rdata !== 32'hA000_0004 || if_rdata !== 32'hA000_0003) begin
         n_bad++; $display("FAIL rr_final: done if/d/err %b%b%b want 010, d_rdata %h want a0000004, if_rdata %h want a0000003",
                           if_done, d_done, d_err, d_rdata, if_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_stray_ack();
      m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      m_ack = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m_valid, if_done, d_done} !== 3'b000 || if_rdata !== 32'hA000_0003 || d_rdata !== 32'hA000_0004) begin
         n_bad++; $display("FAIL stray_ack: valid/done %b%b%b want 000, if_rdata %h d_rdata %h", m_valid, if_done, d_done, if_rdata, d_rdata);
      end
   endtask

   task automatic test_fetch();
      if_req = 1'b1; if_addr = 12'h013;
      @(negedge clk);
      if_req = 1'b0;
      n_cmp++;
      if ({m_valid, m_word, m_we, m_byte, m_half} !== 5'b11000 || m_addr !== 12'h010) begin
         n_bad++; $display("FAIL fetch_access: valid/word/we/byte/half %b want 11000, m_addr %h want 010",
                           {m_valid, m_word, m_we, m_byte, m_half}, m_addr);
      end
      @(negedge clk);
      m_ack = 1'b1; m_rdata = 32'h0050_0093;
      n_cmp++;
      if (m_valid !== 1'b1 || m_addr !== 12'h010 || if_done !== 1'b0) begin
         n_bad++; $display("FAIL fetch_hold: valid %b addr %h done %b want 1 010 0", m_valid, m_addr, if_done);
      end
      @(negedge clk);
      m_ack = 1'b0;
      n_cmp++;
      if ({if_done, if_err, d_done, m_valid} !== 4'b1000 || if_rdata !== 32'h0050_0093) begin
         n_bad++; $display("FAIL fetch_done: done/err/d_done/valid %b want 1000, if_rdata %h want 00500093",
                           {if_done, if_err, d_done, m_valid}, if_rdata);
      end
      @(negedge clk);
      n_cmp++;
      if ({if_done, m_valid} !== 2'b00) begin
         n_bad++; $display("FAIL fetch_pulse: done/valid %b want 00", {if_done, m_valid});
      end
   endtask

   task automatic test_illegal();
      logic [2:0] sizes [2];
      logic [11:0] addrs [2];
      sizes[0] = 3'b010; addrs[0] = 12'h101;
      sizes[1] = 3'b101; addrs[1] = 12'h100;
      for (int k = 0; k < 2; k++) begin
         d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h1111_2222;
         {d_byte, d_half, d_word} = sizes[k]; d_addr = addrs[k];
         @(negedge clk);
         d_req = 1'b0;
         n_cmp++;
         if ({d_done, d_err, m_valid, if_done} !== 4'b1100 || d_rdata !== 32'hA000_0004) begin
            n_bad++; $display("FAIL illegal%0d: done/err/valid/if_done %b want 1100, d_rdata %h want a0000004",
                              k, {d_done, d_err, m_valid, if_done}, d_rdata);
         end
         @(negedge clk);
         n_cmp++;
         if ({d_done, d_err, m_valid} !== 3'b000) begin
            n_bad++; $display("FAIL illegal%0d_after: done/err/valid %b want 000", k, {d_done, d_err, m_valid});
         end
      end
      {d_byte, d_half, d_word} = 3'b001; d_we = 1'b0;
   endtask

   task automatic test_timeout();
      int valid_cnt;
      int done_at;
      logic err_at_done;
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h040;
      valid_cnt = 0; done_at = 0; err_at_done = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         d_req = 1'b0;
         if (m_valid) valid_cnt++;
         if (d_done && done_at == 0) begin
            done_at = c; err_at_done = d_err;
         end
      end
      n_cmp++;
      if (valid_cnt != 16 || done_at != 17) begin
         n_bad++; $display("FAIL timeout_len: m_valid cycles %0d want 16, done at %0d want 17", valid_cnt, done_at);
      end
      n_cmp++;
      if (err_at_done !== 1'b1 || d_rdata !== 32'hA000_0004) begin
         n_bad++; $display("FAIL timeout_err: d_err %b want 1, d_rdata %h want a0000004", err_at_done, d_rdata);
      end
   endtask

   task automatic test_addr_hold();
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h080;
      @(negedge clk);
      d_req = 1'b0; d_addr = 12'h0C4;
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if (m_valid !== 1'b1 || m_addr !== 12'h080 || d_done !== 1'b0) begin
            n_bad++; $display("FAIL hold_addr%0d: valid %b addr %h done %b want 1 080 0", c, m_valid, m_addr, d_done);
         end
         if (c == 2) begin
            m_ack = 1'b1; m_rdata = 32'h1234_5678;
         end
         @(negedge clk);
      end
      m_ack = 1'b0;
      n_cmp++;
      if ({d_done, d_err} !== 2'b10 || d_rdata !== 32'h1234_5678) begin
         n_bad++; $display("FAIL hold_done: done/err %b want 10, d_rdata %h want 12345678", {d_done, d_err}, d_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midaccess();
      if_req = 1'b1; if_addr = 12'h300;
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b1 || m_addr !== 12'h300) begin
         n_bad++; $display("FAIL rmid_busy: valid %b addr %h want 1 300", m_valid, m_addr);
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({m_valid, m_word, if_done, d_done} !== 4'b0000 || m_addr !== 12'h000 || d_rdata !== 32'd0) begin
         n_bad++; $display("FAIL rmid_async: valid/word/done %b addr %h d_rdata %h want all 0",
                           {m_valid, m_word, if_done, d_done}, m_addr, d_rdata);
      end
      @(negedge clk);
      n_cmp++;
      if ({if_done, m_valid} !== 2'b00) begin
         n_bad++; $display("FAIL rmid_held: done/valid %b want 00", {if_done, m_valid});
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b1 || m_addr !== 12'h300 || if_done !== 1'b0) begin
         n_bad++; $display("FAIL rmid_regrant: valid %b addr %h done %b want 1 300 0", m_valid, m_addr, if_done);
      end
      if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      m_ack = 1'b0;
      n_cmp++;
      if ({if_done, if_err} !== 2'b10 || if_rdata !== 32'h0BAD_F00D) begin
         n_bad++; $display("FAIL rmid_done: done/err %b want 10, if_rdata %h want 0badf00d", {if_done, if_err}, if_rdata);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_stray_ack();
      test_fetch();
      test_illegal();
      test_timeout();
      test_addr_hold();
      test_reset_midaccess();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
